// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is a pure state decode, so no combinational path runs from out_ready to in_ready.
module pipe_stage_reg #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_mainData;
    logic [WIDTH-1:0] r_skidData;
    logic             w_inFire;
    logic             w_outFire;

    assign in_ready  = (r_state != FULL) && !flush;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_mainData;
    assign occupancy = r_state;

    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = out_valid && out_ready;

    // The main reg always holds the oldest beat; the skid reg only fills when the
    // stage is already occupied and downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_mainData <= RESET_VAL;
            r_skidData <= RESET_VAL;
        end else if (flush) begin
            r_state    <= EMPTY;
            r_mainData <= RESET_VAL;
            r_skidData <= RESET_VAL;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_inFire) begin
                        r_state    <= ONE;
                        r_mainData <= in_data;
                    end
                end
                ONE: begin
                    if (w_inFire && w_outFire) begin
                        r_mainData <= in_data;
                    end else if (w_inFire) begin
                        r_state    <= FULL;
                        r_skidData <= in_data;
                    end else if (w_outFire) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_outFire) begin
                        r_state    <= ONE;
                        r_mainData <= r_skidData;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

endmodule
